// File: rtl/pulse_frame_scheduler.sv
// Round-robin frame scheduler granting one requester at a time a FRAME_LEN-cycle pulse frame.
// Optional abort input enabled by defining PSCHED_ABORT_EN.
module pulse_frame_scheduler #(
    parameter int NREQ      = 4,
    parameter int FRAME_LEN = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
`ifdef PSCHED_ABORT_EN
    input  logic                 abort,
`endif
    input  logic [NREQ-1:0]      req,
    input  logic [2*NREQ-1:0]    req_mode,
    output logic [NREQ-1:0]      gnt,
    output logic [1:0]           mode,
    output logic                 frame_start,
    output logic [3:0]           step,
    output logic                 busy,
    output logic [NREQ-1:0]      done
);

    localparam int         PW        = $clog2(NREQ);
    localparam logic [3:0] LAST_STEP = 4'(FRAME_LEN - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      step_q, step_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [1:0]      mode_q, mode_d;
    logic [PW-1:0]   last_q, last_d;

    logic [1:0]      mode_arr [NREQ];
    logic            any_req;
    logic            found;
    logic [PW-1:0]   cand;
    logic [PW-1:0]   win;
    logic            abort_w;
    logic            last_step;

`ifdef PSCHED_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    for (genvar g = 0; g < NREQ; g++) begin : g_mode
        assign mode_arr[g] = req_mode[2*g +: 2];
    end

    assign any_req = |req;

    // Search begins one past the last winner and wraps, so the first hit is the round-robin choice.
    always_comb begin
        found = 1'b0;
        cand  = '0;
        win   = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            cand = PW'((32'(last_q) + i) % NREQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    assign busy        = (state_q == RUN);
    assign last_step   = busy && (step_q == LAST_STEP);
    assign frame_start = busy && (step_q == 4'd0);
    assign done        = (last_step && !abort_w) ? gnt_q : '0;
    assign gnt         = gnt_q;
    assign mode        = mode_q;
    assign step        = step_q;

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        gnt_d   = gnt_q;
        mode_d  = mode_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d    = RUN;
                    step_d     = '0;
                    gnt_d      = '0;
                    gnt_d[win] = 1'b1;
                    mode_d     = mode_arr[win];
                    last_d     = win;
                end
            end
            RUN: begin
                if (abort_w) begin
                    state_d = IDLE;
                    step_d  = '0;
                    gnt_d   = '0;
                    mode_d  = '0;
                end else if (last_step) begin
                    // Re-arbitrate on the final step so a pending request starts with no gap.
                    if (any_req) begin
                        state_d    = RUN;
                        step_d     = '0;
                        gnt_d      = '0;
                        gnt_d[win] = 1'b1;
                        mode_d     = mode_arr[win];
                        last_d     = win;
                    end else begin
                        state_d = IDLE;
                        step_d  = '0;
                        gnt_d   = '0;
                        mode_d  = '0;
                    end
                end else begin
                    step_d = step_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                step_d  = '0;
                gnt_d   = '0;
                mode_d  = '0;
            end
        endcase
    end

    // Pointer resets to the top index so requester 0 is searched first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            step_q  <= '0;
            gnt_q   <= '0;
            mode_q  <= '0;
            last_q  <= PW'(NREQ - 1);
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            gnt_q   <= gnt_d;
            mode_q  <= mode_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: doc/pulse_frame_scheduler.md
PULSE_FRAME_SCHEDULER -- requirements
Module: pulse_frame_scheduler

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the pulse generator; range 2..8.
REQ-002 Parameter FRAME_LEN, default 12: cycles per pulse frame, matching the generator's 12-state cycle; range 2..16.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1: reset; asynchronous, active-low.
REQ-005 Port req, input, NREQ: per-requester frame request, level-sensitive.
REQ-006 Port req_mode, input, 2*NREQ: requester k's 2-bit generator mode at bits [2k+1:2k].
REQ-007 Port gnt, output, NREQ: one-hot grant, held for the whole frame; all-zero when idle.
REQ-008 Port mode, output, 2: mode latched from the granted requester; drives the generator's 2-bit I input.
REQ-009 Port frame_start, output, 1: one-cycle pulse on step 0 of every frame.
REQ-010 Port step, output, 4: current frame step, 0..FRAME_LEN-1; 0 when idle.
REQ-011 Port busy, output, 1: high while a frame runs.
REQ-012 Port done, output, NREQ: one-cycle pulse on the granted requester's bit during step FRAME_LEN-1.

Function
REQ-013 FSM SHALL have two states: IDLE and RUN.
REQ-014 In IDLE, if any req bit is high, the FSM SHALL arbitrate and enter RUN next cycle with step=0, gnt, mode, frame_start=1 and busy=1 all valid.
REQ-015 Arbitration SHALL be round-robin: search starts at the index after the last granted requester, wrapping NREQ-1 -> 0.
REQ-016 The winner's req_mode SHALL be latched at arbitration; later req_mode changes SHALL NOT affect mode during the frame.
REQ-017 In RUN, step SHALL increment by 1 per cycle; gnt and mode SHALL stay constant.
REQ-018 At step FRAME_LEN-1, done SHALL pulse for the granted requester, and req SHALL be re-arbitrated in that same cycle.
REQ-019 If any req is high at step FRAME_LEN-1, the next frame SHALL start on the next cycle (step=0, frame_start=1), with no idle gap.
REQ-020 If no req is high at step FRAME_LEN-1, the FSM SHALL return to IDLE next cycle.
REQ-021 A sole requester holding req high SHALL be re-granted back-to-back.
REQ-022 Deasserting req mid-frame SHALL NOT shorten or cancel the frame.
REQ-023 In IDLE: gnt=0, mode=2'b00, step=0, busy=0, frame_start=0, done=0.
REQ-024 Latency SHALL be exactly 1 cycle from sampled req (in IDLE) to gnt.

Reset
REQ-025 Asserting rst_n low SHALL immediately force IDLE, with all outputs at their REQ-023 values and the round-robin pointer set so requester 0 has highest priority.
REQ-026 Reset during RUN SHALL abandon the frame without pulsing done.
REQ-027 After rst_n deasserts, arbitration SHALL resume on the first rising edge.

Configuration
REQ-028 Macro PSCHED_ABORT_EN, when defined, SHALL add input port abort, 1 bit.
REQ-029 With the macro defined, abort high in RUN SHALL force IDLE next cycle, with no done pulse and the round-robin pointer advanced past the aborted requester.
REQ-030 With the macro defined, abort SHALL take priority over REQ-018/019 at step FRAME_LEN-1 (no done, no new grant that cycle); abort in IDLE SHALL be ignored.
REQ-031 Without the macro, port abort SHALL NOT exist, and every frame SHALL run exactly FRAME_LEN cycles.

Verification
REQ-032 req=4'b0001, req_mode[1:0]=2'b10 in IDLE -> next cycle gnt=0001, mode=10, frame_start=1; done[0] pulses 12 cycles later (step 11); then IDLE once req drops.
REQ-033 req=4'b1111 held -> grants 0001, 0010, 0100, 1000, 0001, each lasting 12 cycles, with no gaps between frames.
REQ-034 Change req_mode[1:0] from 01 to 11 at step 5 of requester 0's frame -> mode stays 01 until the frame ends.
REQ-035 Pull rst_n low at step 7 -> outputs go to idle values asynchronously with no done pulse; after release, req=4'b0100 -> gnt=0100 next cycle.
REQ-036 PSCHED_ABORT_EN defined: abort=1 at step 3 of requester 1's frame -> IDLE next cycle with no done; with req=4'b0011 still high, the next grant is 0001.
REQ-037 PSCHED_ABORT_EN defined: abort=1 at step 11 -> no done and no new frame, even with req pending.
